// File: rtl/accel_pkg.sv
// Shared types for the processing-unit array front end: packet/command layouts,
// unit states and the packet decoder used by the dispatcher.
package accel_pkg;

    localparam int NUM_PROCESSING_UNITS = 4;
    localparam int DISPATCH_FIFO_DEPTH  = 4;
    localparam int CTRL_PACKET_W        = 14;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSFER = 2'd1,
        COMPUTE  = 2'd2
    } unit_state_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_COMP  = 2'd3
    } operation_code_t;

    typedef struct packed {
        logic [1:0]      unit_id;
        operation_code_t op_code;
        logic [1:0]      comp_type;
        logic [3:0]      addr;
        logic            valid;
        logic [2:0]      size;
    } control_signal_t;

    typedef struct packed {
        logic [5:0] encoded_control;
        logic [7:0] data_control;
    } control_packet_t;

    function automatic control_signal_t decode_packet(input control_packet_t pkt);
        control_signal_t sig;
        sig.unit_id   = pkt.encoded_control[5:4];
        sig.op_code   = operation_code_t'(pkt.encoded_control[3:2]);
        sig.comp_type = pkt.encoded_control[1:0];
        sig.addr      = pkt.data_control[7:4];
        sig.valid     = pkt.data_control[3];
        sig.size      = pkt.data_control[2:0];
        return sig;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with occupancy count; pushes when full and pops when
// empty are ignored. DEPTH must be a power of two so the pointers wrap freely.
module cmd_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/unit_dispatcher.sv
// Buffers host command packets, dispatches them in order to idle processing units
// through a single command register, and tracks each unit's busy state.
module unit_dispatcher
    import accel_pkg::*;
#(
    parameter int NUM_UNITS  = NUM_PROCESSING_UNITS,
    parameter int FIFO_DEPTH = DISPATCH_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pkt_valid,
    output logic                          pkt_ready,
    input  control_packet_t               pkt_in,
    output logic [NUM_UNITS-1:0]          unit_cmd_valid,
    output control_signal_t               unit_cmd,
    input  logic [NUM_UNITS-1:0]          unit_cmd_ready,
    input  logic [NUM_UNITS-1:0]          unit_done,
    output unit_state_t [NUM_UNITS-1:0]   unit_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          err_drop,
    output logic                          err_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                        w_fifo_empty;
    logic [CTRL_PACKET_W-1:0]    w_fifo_data;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_load;
    logic                        w_drop;
    logic                        w_hs;
    logic [NUM_UNITS-1:0]        w_hs_vec;
    logic [NUM_UNITS-1:0]        w_idle_vec;
    control_signal_t             w_head;

    logic                        r_cmd_full;
    control_signal_t             r_cmd;
    unit_state_t [NUM_UNITS-1:0] r_state;
    logic                        r_err_drop;
    logic                        r_err_done;

    assign pkt_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign w_push    = pkt_valid && pkt_ready;

    cmd_fifo #(
        .WIDTH (CTRL_PACKET_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (pkt_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    assign w_head = decode_packet(control_packet_t'(w_fifo_data));

    always_comb begin
        unit_cmd_valid = '0;
        if (r_cmd_full) unit_cmd_valid[r_cmd.unit_id] = 1'b1;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_idle_vec[i] = (r_state[i] == IDLE);
        end
    end

    // Only the targeted unit's ready counts, so the handshake vector is one-hot at most.
    assign w_hs_vec = unit_cmd_valid & unit_cmd_ready;
    assign w_hs     = |w_hs_vec;

    // A handshaking unit is still IDLE this cycle, hence the explicit same-unit exclusion.
    always_comb begin
        w_pop  = 1'b0;
        w_load = 1'b0;
        w_drop = 1'b0;
        if (!w_fifo_empty) begin
            if (!w_head.valid) begin
                w_pop  = 1'b1;
                w_drop = 1'b1;
            end else if (w_head.op_code == OP_NOP) begin
                w_pop = 1'b1;
            end else if ((!r_cmd_full || w_hs) && (r_state[w_head.unit_id] == IDLE) &&
                         !(w_hs && (w_head.unit_id == r_cmd.unit_id))) begin
                w_pop  = 1'b1;
                w_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_full <= 1'b0;
            r_cmd      <= '0;
        end else if (w_load) begin
            r_cmd_full <= 1'b1;
            r_cmd      <= w_head;
        end else if (w_hs) begin
            r_cmd_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UNITS; i++) r_state[i] <= IDLE;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (r_state[i] == IDLE) begin
                    if (w_hs_vec[i]) begin
                        if (r_cmd.op_code == OP_COMP) r_state[i] <= COMPUTE;
                        else if (r_cmd.op_code != OP_NOP) r_state[i] <= TRANSFER;
                    end
                end else if (unit_done[i]) begin
                    r_state[i] <= IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_drop <= 1'b0;
            r_err_done <= 1'b0;
        end else begin
            r_err_drop <= w_drop;
            r_err_done <= |(unit_done & w_idle_vec);
        end
    end

    assign unit_cmd   = r_cmd_full ? r_cmd : '0;
    assign unit_state = r_state;
    assign busy       = !w_fifo_empty || r_cmd_full || (w_idle_vec != {NUM_UNITS{1'b1}});
    assign err_drop   = r_err_drop;
    assign err_done   = r_err_done;

endmodule

// File: tb/tb_unit_dispatcher.sv
// Scoreboard bench for unit_dispatcher: expected dispatches are queued as packets
// are accepted and matched against every command handshake.
module tb_unit_dispatcher;
    import accel_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              pkt_valid;
    logic              pkt_ready;
    control_packet_t   pkt_in;
    logic [3:0]        unit_cmd_valid;
    control_signal_t   unit_cmd;
    logic [3:0]        unit_cmd_ready;
    logic [3:0]        unit_done;
    unit_state_t [3:0] unitState;
    logic [2:0]        fifo_count;
    logic              busy;
    logic              err_drop;
    logic              err_done;

    int checkCount = 0;
    int errorCount = 0;
    int dropPulses = 0;
    logic [13:0] sb [$];

    unit_dispatcher #(.NUM_UNITS(4), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_in         (pkt_in),
        .unit_cmd_valid (unit_cmd_valid),
        .unit_cmd       (unit_cmd),
        .unit_cmd_ready (unit_cmd_ready),
        .unit_done      (unit_done),
        .unit_state     (unitState),
        .fifo_count     (fifo_count),
        .busy           (busy),
        .err_drop       (err_drop),
        .err_done       (err_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [13:0] mkPkt(input logic [1:0] u, input logic [1:0] op, input logic [1:0] comp,
                                          input logic [3:0] addr, input logic v, input logic [2:0] sz);
        return {u, op, comp, addr, v, sz};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one packet for one edge; dispatchable packets become scoreboard entries.
    task automatic applyStimulus(input logic [13:0] p, output bit accepted);
        pkt_in    = control_packet_t'(p);
        pkt_valid = 1'b1;
        accepted  = pkt_ready;
        tick();
        pkt_valid = 1'b0;
        if (accepted && p[3] && (p[11:10] != 2'b00)) begin
            sb.push_back({p[13:12], p[11:10], p[9:8], p[7:4], p[3], p[2:0]});
        end
    endtask

    // Acts as a cooperative unit array until everything in flight has completed.
    task automatic drainAll();
        int n = 0;
        unit_cmd_ready = 4'b1111;
        while ((busy || sb.size() != 0) && n < 200) begin
            for (int i = 0; i < 4; i++) unit_done[i] = (unitState[i] != IDLE);
            tick();
            n++;
        end
        unit_done      = 4'b0000;
        unit_cmd_ready = 4'b0000;
        checkOutput("drainBusy", {31'b0, busy}, 32'd0);
        checkOutput("drainQueue", sb.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (err_drop) dropPulses++;
            if ((unit_cmd_valid & unit_cmd_ready) != 4'b0000) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpectedDispatch", {28'b0, unit_cmd_valid}, 32'd0);
                end else begin
                    logic [13:0] exp;
                    logic [3:0]  expHot;
                    exp    = sb.pop_front();
                    expHot = 4'b0001 << exp[13:12];
                    checkOutput("dispatchCmd", {18'b0, unit_cmd}, {18'b0, exp});
                    checkOutput("dispatchOneHot", {28'b0, unit_cmd_valid}, {28'b0, expHot});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit         acc;
        logic [3:0] seen [5];
        int         dropBase;

        rst_n = 1'b0; pkt_valid = 1'b0; pkt_in = '0;
        unit_cmd_ready = 4'b0000; unit_done = 4'b0000;
        #12;
        checkOutput("rstReady", {31'b0, pkt_ready}, 32'd1);
        checkOutput("rstCount", {29'b0, fifo_count}, 32'd0);
        checkOutput("rstValid", {28'b0, unit_cmd_valid}, 32'd0);
        checkOutput("rstCmd", {18'b0, unit_cmd}, 32'd0);
        checkOutput("rstState", {24'b0, unitState}, 32'd0);
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstErr", {30'b0, err_drop, err_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] single LOAD to unit 1");
        applyStimulus(mkPkt(2'd1, 2'd1, 2'd0, 4'd3, 1'b1, 3'd2), acc);
        checkOutput("t1Accepted", {31'b0, acc}, 32'd1);
        checkOutput("t1Cycle1Valid", {28'b0, unit_cmd_valid}, 32'd0);
        checkOutput("t1Count", {29'b0, fifo_count}, 32'd1);
        tick();
        checkOutput("t1Cycle2Valid", {28'b0, unit_cmd_valid}, 32'b0010);
        checkOutput("t1Addr", {28'b0, unit_cmd.addr}, 32'd3);
        checkOutput("t1Size", {29'b0, unit_cmd.size}, 32'd2);
        unit_cmd_ready = 4'b0010;
        tick();
        unit_cmd_ready = 4'b0000;
        checkOutput("t1Transfer", {30'b0, unitState[1]}, {30'b0, TRANSFER});
        checkOutput("t1ValidDrop", {28'b0, unit_cmd_valid}, 32'd0);
        unit_done = 4'b0010;
        tick();
        unit_done = 4'b0000;
        checkOutput("t1Idle", {30'b0, unitState[1]}, {30'b0, IDLE});
        checkOutput("t1NotBusy", {31'b0, busy}, 32'd0);

        $display("[TB] fill FIFO with ready low");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mkPkt(2'd0, 2'd1, 2'd0, 4'(i + 4), 1'b1, 3'd1), acc);
            checkOutput("t2Accepted", {31'b0, acc}, 32'd1);
        end
        checkOutput("t2CountFull", {29'b0, fifo_count}, 32'd4);
        checkOutput("t2ReadyLow", {31'b0, pkt_ready}, 32'd0);
        applyStimulus(mkPkt(2'd1, 2'd1, 2'd0, 4'd15, 1'b1, 3'd1), acc);
        checkOutput("t2SixthRejected", {31'b0, acc}, 32'd0);
        checkOutput("t2CountHeld", {29'b0, fifo_count}, 32'd4);
        drainAll();

        $display("[TB] same-unit blocking and in-order wait");
        unit_cmd_ready = 4'b1111;
        applyStimulus(mkPkt(2'd2, 2'd3, 2'd1, 4'd1, 1'b1, 3'd0), acc);
        applyStimulus(mkPkt(2'd2, 2'd3, 2'd2, 4'd2, 1'b1, 3'd0), acc);
        applyStimulus(mkPkt(2'd0, 2'd3, 2'd3, 4'd7, 1'b1, 3'd5), acc);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("t3Blocked", {28'b0, unit_cmd_valid}, 32'd0);
        checkOutput("t3U2Compute", {30'b0, unitState[2]}, {30'b0, COMPUTE});
        checkOutput("t3U0Waits", {30'b0, unitState[0]}, {30'b0, IDLE});
        checkOutput("t3Count", {29'b0, fifo_count}, 32'd2);
        unit_done = 4'b0100;
        tick();
        unit_done = 4'b0000;
        checkOutput("t3DoneIdle", {30'b0, unitState[2]}, {30'b0, IDLE});
        checkOutput("t3NoEarlyDispatch", {28'b0, unit_cmd_valid}, 32'd0);
        tick();
        checkOutput("t3SecondDispatch", {28'b0, unit_cmd_valid}, 32'b0100);
        tick();
        checkOutput("t3ThirdBackToBack", {28'b0, unit_cmd_valid}, 32'b0001);
        drainAll();

        $display("[TB] back-to-back dispatch to units 0,1,2");
        unit_cmd_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkPkt(2'(i), 2'd1, 2'd0, 4'(i + 8), 1'b1, 3'(i)), acc);
            seen[i] = unit_cmd_valid;
        end
        tick(); seen[3] = unit_cmd_valid;
        tick(); seen[4] = unit_cmd_valid;
        checkOutput("t4Cycle1", {28'b0, seen[0]}, 32'b0000);
        checkOutput("t4Cycle2", {28'b0, seen[1]}, 32'b0001);
        checkOutput("t4Cycle3", {28'b0, seen[2]}, 32'b0010);
        checkOutput("t4Cycle4", {28'b0, seen[3]}, 32'b0100);
        checkOutput("t4Cycle5", {28'b0, seen[4]}, 32'b0000);
        drainAll();

        $display("[TB] dropped packet, NOP, then STORE to unit 3");
        dropBase = dropPulses;
        unit_cmd_ready = 4'b1111;
        applyStimulus(mkPkt(2'd3, 2'd1, 2'd0, 4'd5, 1'b0, 3'd3), acc);
        checkOutput("t5DropCycle1", {31'b0, err_drop}, 32'd0);
        applyStimulus(mkPkt(2'd3, 2'd0, 2'd0, 4'd6, 1'b1, 3'd3), acc);
        checkOutput("t5DropPulse", {31'b0, err_drop}, 32'd1);
        applyStimulus(mkPkt(2'd3, 2'd2, 2'd1, 4'd9, 1'b1, 3'd4), acc);
        checkOutput("t5DropCleared", {31'b0, err_drop}, 32'd0);
        checkOutput("t5NopNoDispatch", {28'b0, unit_cmd_valid}, 32'd0);
        tick();
        checkOutput("t5StoreDispatch", {28'b0, unit_cmd_valid}, 32'b1000);
        tick();
        checkOutput("t5U3Transfer", {30'b0, unitState[3]}, {30'b0, TRANSFER});
        checkOutput("t5DropCount", dropPulses - dropBase, 32'd1);
        drainAll();

        $display("[TB] done while idle");
        unit_done = 4'b0001;
        tick();
        unit_done = 4'b0000;
        checkOutput("t6ErrDone", {31'b0, err_done}, 32'd1);
        checkOutput("t6StillIdle", {30'b0, unitState[0]}, {30'b0, IDLE});
        tick();
        checkOutput("t6ErrDoneCleared", {31'b0, err_done}, 32'd0);

        $display("[TB] asynchronous reset mid-operation");
        unit_cmd_ready = 4'b0010;
        applyStimulus(mkPkt(2'd1, 2'd3, 2'd0, 4'd2, 1'b1, 3'd1), acc);
        tick();
        tick();
        unit_cmd_ready = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkPkt(2'd1, 2'd1, 2'd0, 4'(i), 1'b1, 3'd1), acc);
        end
        checkOutput("t7U1Compute", {30'b0, unitState[1]}, {30'b0, COMPUTE});
        checkOutput("t7Count3", {29'b0, fifo_count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("t7RstCount", {29'b0, fifo_count}, 32'd0);
        checkOutput("t7RstState", {24'b0, unitState}, 32'd0);
        checkOutput("t7RstBusy", {31'b0, busy}, 32'd0);
        checkOutput("t7RstReady", {31'b0, pkt_ready}, 32'd1);
        checkOutput("t7RstValid", {28'b0, unit_cmd_valid}, 32'd0);
        checkOutput("t7RstCmd", {18'b0, unit_cmd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("t7PostBusy", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
